// File: rtl/alu_secuenciador.sv
// alu_secuenciador: sequencing controller in front of the MicroUAZ ALU.
// Takes one instruction (opcode, A, B) over a valid/ready handshake and
// drives the ALU operand and opcode lines. Multi-bit shifts run as repeated
// single-position passes. The result and its zero/negative/error flags are
// returned over a second valid/ready handshake. Every output is a flop.
module alu_secuenciador #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_valid,
    output logic          inst_ready,
    input  logic [3:0]    inst_op,
    input  logic [N-1:0]  inst_a,
    input  logic [N-1:0]  inst_b,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [3:0]    alu_op,
    input  logic [N-1:0]  alu_res,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_zero,
    output logic          res_neg,
    output logic          res_err
);

    // ------------------------------------------------------------------
    // Opcodes and constants
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0010;
    localparam logic [3:0] OP_SHR = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_NOP = 4'b1111;

    // Shift counts at or above N saturate to N (result is 0 for a logical shift).
    localparam logic [N-1:0]  SAT_DATA = N'(N);
    localparam logic [CW-1:0] SAT_CNT  = CW'(N);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  DATA_ZERO = {N{1'b0}};
    localparam logic [N-1:0]  DATA_ONE  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic op_is_shift(input logic [3:0] op);
        logic r;
        case (op)
            OP_SHL:  r = 1'b1;
            OP_SHR:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_defined(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_SHL, OP_SHR,
            OP_AND, OP_OR,  OP_NOT, OP_XOR,
            OP_NOP:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [CW-1:0] sat_count(input logic [N-1:0] b);
        logic [CW-1:0] r;
        if (b >= SAT_DATA) begin
            r = SAT_CNT;
        end else begin
            r = b[CW-1:0];
        end
        return r;
    endfunction

    function automatic logic flag_zero(input logic [N-1:0] d);
        return (d == DATA_ZERO);
    endfunction

    function automatic logic flag_neg(input logic [N-1:0] d);
        return d[N-1];
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t         state_q,      state_d;
    logic [N-1:0]   acc_q,        acc_d;
    logic [N-1:0]   b_q,          b_d;
    logic [3:0]     op_q,         op_d;
    logic [CW-1:0]  count_q,      count_d;
    logic           err_q,        err_d;
    logic [N-1:0]   res_data_q,   res_data_d;
    logic           res_zero_q,   res_zero_d;
    logic           res_neg_q,    res_neg_d;

    // Output flops (next value derived from the next state)
    logic           inst_ready_q, inst_ready_d;
    logic           res_valid_q,  res_valid_d;
    logic [N-1:0]   alu_a_q,      alu_a_d;
    logic [N-1:0]   alu_b_q,      alu_b_d;
    logic [3:0]     alu_op_q,     alu_op_d;

    // Next-state and datapath update logic for the IDLE/EXEC/HOLD sequencer.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        b_d        = b_q;
        op_d       = op_q;
        count_d    = count_q;
        err_d      = err_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        res_neg_d  = res_neg_q;

        case (state_q)
            ST_IDLE: begin
                if (inst_valid) begin
                    acc_d   = inst_a;
                    b_d     = inst_b;
                    state_d = ST_EXEC;
                    if (op_is_defined(inst_op)) begin
                        op_d  = inst_op;
                        err_d = 1'b0;
                    end else begin
                        // Undefined opcodes execute as nop and flag an error.
                        op_d  = OP_NOP;
                        err_d = 1'b1;
                    end
                    if (op_is_shift(inst_op)) begin
                        count_d = sat_count(inst_b);
                    end else begin
                        count_d = CNT_ZERO;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                if (op_is_shift(op_q)) begin
                    if (count_q == CNT_ZERO) begin
                        // Zero-position shift returns the operand unchanged.
                        res_data_d = acc_q;
                        res_zero_d = flag_zero(acc_q);
                        res_neg_d  = flag_neg(acc_q);
                        state_d    = ST_HOLD;
                    end else begin
                        acc_d   = alu_res;
                        count_d = count_q - CNT_ONE;
                        if (count_q == CNT_ONE) begin
                            res_data_d = alu_res;
                            res_zero_d = flag_zero(alu_res);
                            res_neg_d  = flag_neg(alu_res);
                            state_d    = ST_HOLD;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                end else begin
                    res_data_d = alu_res;
                    res_zero_d = flag_zero(alu_res);
                    res_neg_d  = flag_neg(alu_res);
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values: ALU lines and handshake strobes follow the next state
    // so that registered outputs line up with the cycle they belong to.
    always_comb begin
        inst_ready_d = 1'b0;
        res_valid_d  = 1'b0;
        alu_a_d      = DATA_ZERO;
        alu_b_d      = DATA_ZERO;
        alu_op_d     = OP_NOP;

        case (state_d)
            ST_IDLE: begin
                inst_ready_d = 1'b1;
            end
            ST_EXEC: begin
                alu_a_d  = acc_d;
                alu_op_d = op_d;
                if (op_is_shift(op_d)) begin
                    alu_b_d = DATA_ONE;
                end else begin
                    alu_b_d = b_d;
                end
            end
            ST_HOLD: begin
                res_valid_d = 1'b1;
            end
            default: begin
                inst_ready_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= DATA_ZERO;
            b_q          <= DATA_ZERO;
            op_q         <= OP_NOP;
            count_q      <= CNT_ZERO;
            err_q        <= 1'b0;
            res_data_q   <= DATA_ZERO;
            res_zero_q   <= 1'b1;
            res_neg_q    <= 1'b0;
            inst_ready_q <= 1'b1;
            res_valid_q  <= 1'b0;
            alu_a_q      <= DATA_ZERO;
            alu_b_q      <= DATA_ZERO;
            alu_op_q     <= OP_NOP;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            b_q          <= b_d;
            op_q         <= op_d;
            count_q      <= count_d;
            err_q        <= err_d;
            res_data_q   <= res_data_d;
            res_zero_q   <= res_zero_d;
            res_neg_q    <= res_neg_d;
            inst_ready_q <= inst_ready_d;
            res_valid_q  <= res_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
        end
    end

    assign inst_ready = inst_ready_q;
    assign res_valid  = res_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign res_data   = res_data_q;
    assign res_zero   = res_zero_q;
    assign res_neg    = res_neg_q;
    assign res_err    = err_q;

endmodule
